rf_write_arbiter: RTL and testbench

Round-robin arbiter sharing the register file's single write port among independent write sources: ALU/memory writeback, link writes (PC+2 into R7 for JAL/JALR) and load-byte-immediate writes. Sits between the writeback-side producers and the register file write port. Registers the winning request so that the register file sees a clean one-cycle write strobe. Exports a busy mask of the register being written for hazard detection.

---
 rtl/rf_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 56 +++++
 rtl/rf_write_arbiter.sv | 81 ++++++++
 tb/tb_rf_write_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rf_pkg                                                                     |
// | Register-file constants and write-requester indices shared by the block.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package rf_pkg;

    localparam int REG_SEL_W  = 3;
    localparam int REG_DATA_W = 16;
    localparam int NUM_REGS   = 8;

    localparam int REQ_WB   = 0;
    localparam int REQ_LINK = 1;
    localparam int REQ_LBI  = 2;

    localparam logic [REG_SEL_W-1:0] LINK_REG = 3'd7;

    typedef logic [REG_SEL_W-1:0]  reg_sel_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arbiter                                                                 |
// | Parameterized round-robin grant logic with its priority pointer register.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0]   c_num_req = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] c_last    = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W:0]   w_idx;
    logic [PTR_W-1:0] w_win;
    logic             w_found;
    logic             w_grant;

    // Scan ptr, ptr+1, ... with wrap; one extra index bit keeps the sum exact.
    always_comb begin
        w_idx   = '0;
        w_win   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_idx >= c_num_req) begin
                w_idx = w_idx - c_num_req;
            end
            if (!w_found && req[w_idx[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[PTR_W-1:0];
            end
        end
    end

    assign w_grant = w_found & en & ~rst;
    assign gnt     = w_grant ? (NUM_REQ'(1) << w_win) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            r_ptr <= (w_win == c_last) ? '0 : w_win + PTR_W'(1);
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rf_write_arbiter                                                           |
// | Shares the register-file write port among writeback, link and LBI sources. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int NUM_REQ    = REQ_LBI + 1,
    parameter int DATA_WIDTH = REG_DATA_W,
    parameter int SEL_WIDTH  = REG_SEL_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            stall,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*SEL_WIDTH-1:0]    req_sel,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              gnt,
    output logic                            rf_wr_en,
    output logic [SEL_WIDTH-1:0]            rf_wr_sel,
    output logic [DATA_WIDTH-1:0]           rf_wr_data,
    output logic [(2**SEL_WIDTH)-1:0]       busy_mask
);

    localparam int c_num_regs = 2**SEL_WIDTH;

    logic                  w_xfer;
    logic [SEL_WIDTH-1:0]  w_sel;
    logic [DATA_WIDTH-1:0] w_data;

    logic                  r_wr_en;
    logic [SEL_WIDTH-1:0]  r_wr_sel;
    logic [DATA_WIDTH-1:0] r_wr_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk (clk),
        .rst (rst),
        .en  (~stall),
        .req (req),
        .gnt (gnt)
    );

    assign w_xfer = |(gnt & req);

    // gnt is one-hot, so an AND-OR mux selects the winner's fields.
    always_comb begin
        w_sel  = '0;
        w_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                w_sel  = w_sel  | req_sel[i*SEL_WIDTH +: SEL_WIDTH];
                w_data = w_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_sel  <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_xfer;
            if (w_xfer) begin
                r_wr_sel  <= w_sel;
                r_wr_data <= w_data;
            end
        end
    end

    assign rf_wr_en   = r_wr_en;
    assign rf_wr_sel  = r_wr_sel;
    assign rf_wr_data = r_wr_data;
    assign busy_mask  = r_wr_en ? (c_num_regs'(1) << r_wr_sel) : '0;

endmodule : rf_write_arbiter
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rf_write_arbiter                                                        |
// | Table-driven directed bench for the register-file write arbiter.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_rf_write_arbiter;
    import rf_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [2:0]  req;
    logic [8:0]  req_sel;
    logic [47:0] req_data;
    logic [2:0]  gnt;
    logic        rf_wr_en;
    logic [2:0]  rf_wr_sel;
    logic [15:0] rf_wr_data;
    logic [7:0]  busy_mask;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        rst;
        logic        stall;
        logic [2:0]  req;
        logic [8:0]  sel;
        logic [47:0] data;
        logic [2:0]  e_gnt;
        logic        e_en;
        logic [2:0]  e_sel;
        logic [15:0] e_data;
        logic [7:0]  e_busy;
    } vec_t;

    vec_t        vecs[$];
    logic [8:0]  cur_sel;
    logic [47:0] cur_data;

    rf_write_arbiter #(
        .NUM_REQ    (3),
        .DATA_WIDTH (16),
        .SEL_WIDTH  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .req        (req),
        .req_sel    (req_sel),
        .req_data   (req_data),
        .gnt        (gnt),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_sel  (rf_wr_sel),
        .rf_wr_data (rf_wr_data),
        .busy_mask  (busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fields(input logic [2:0] s0, input logic [2:0] s1, input logic [2:0] s2,
                          input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
        cur_sel  = {s2, s1, s0};
        cur_data = {d2, d1, d0};
    endtask

    task automatic add(input logic r, input logic s, input logic [2:0] rq, input logic [2:0] eg,
                       input logic een, input logic [2:0] esel, input logic [15:0] edat,
                       input logic [7:0] ebusy);
        vec_t v;
        v.rst = r; v.stall = s; v.req = rq; v.sel = cur_sel; v.data = cur_data;
        v.e_gnt = eg; v.e_en = een; v.e_sel = esel; v.e_data = edat; v.e_busy = ebusy;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; req = '0; req_sel = '0; req_data = '0;

        // Expected outputs are those visible during the row, i.e. from the previous row's edge.
        fields(3'd0, LINK_REG, 3'd0, 16'h0, 16'h0102, 16'h0);
        add(1, 0, 3'b000, 3'b000, 0, 3'd0, 16'h0000, 8'h00);
        add(0, 0, 3'b000, 3'b000, 0, 3'd0, 16'h0000, 8'h00);
        add(0, 0, 3'b000, 3'b000, 0, 3'd0, 16'h0000, 8'h00);
        add(0, 0, 3'b010, 3'b010, 0, 3'd0, 16'h0000, 8'h00);
        add(0, 0, 3'b000, 3'b000, 1, 3'd7, 16'h0102, 8'h80);
        add(0, 0, 3'b000, 3'b000, 0, 3'd7, 16'h0102, 8'h00);
        add(1, 0, 3'b000, 3'b000, 0, 3'd7, 16'h0102, 8'h00);
        // rotation under contention
        fields(3'd1, 3'd7, 3'd3, 16'h1111, 16'h2222, 16'h3333);
        add(0, 0, 3'b111, 3'b001, 0, 3'd0, 16'h0000, 8'h00);
        add(0, 0, 3'b111, 3'b010, 1, 3'd1, 16'h1111, 8'h02);
        add(0, 0, 3'b111, 3'b100, 1, 3'd7, 16'h2222, 8'h80);
        add(0, 0, 3'b111, 3'b001, 1, 3'd3, 16'h3333, 8'h08);
        add(0, 0, 3'b111, 3'b010, 1, 3'd1, 16'h1111, 8'h02);
        add(0, 0, 3'b111, 3'b100, 1, 3'd7, 16'h2222, 8'h80);
        add(0, 0, 3'b010, 3'b010, 1, 3'd3, 16'h3333, 8'h08);
        add(0, 0, 3'b000, 3'b000, 1, 3'd7, 16'h2222, 8'h80);
        // stall with ptr=2
        add(0, 1, 3'b101, 3'b000, 0, 3'd7, 16'h2222, 8'h00);
        add(0, 1, 3'b101, 3'b000, 0, 3'd7, 16'h2222, 8'h00);
        add(0, 1, 3'b101, 3'b000, 0, 3'd7, 16'h2222, 8'h00);
        add(0, 0, 3'b101, 3'b100, 0, 3'd7, 16'h2222, 8'h00);
        add(0, 0, 3'b101, 3'b001, 1, 3'd3, 16'h3333, 8'h08);
        add(0, 0, 3'b000, 3'b000, 1, 3'd1, 16'h1111, 8'h02);
        add(1, 0, 3'b000, 3'b000, 0, 3'd1, 16'h1111, 8'h00);
        // same-register conflict on R4
        fields(3'd4, 3'd7, 3'd4, 16'hAAAA, 16'h2222, 16'h5555);
        add(0, 0, 3'b101, 3'b001, 0, 3'd0, 16'h0000, 8'h00);
        add(0, 0, 3'b101, 3'b100, 1, 3'd4, 16'hAAAA, 8'h10);
        add(0, 0, 3'b000, 3'b000, 1, 3'd4, 16'h5555, 8'h10);
        // reset mid-stream
        fields(3'd1, 3'd7, 3'd3, 16'h1111, 16'h2222, 16'h3333);
        add(0, 0, 3'b111, 3'b001, 0, 3'd4, 16'h5555, 8'h00);
        add(0, 0, 3'b111, 3'b010, 1, 3'd1, 16'h1111, 8'h02);
        add(1, 0, 3'b111, 3'b000, 1, 3'd7, 16'h2222, 8'h80);
        add(0, 0, 3'b111, 3'b001, 0, 3'd0, 16'h0000, 8'h00);
        add(0, 0, 3'b000, 3'b000, 1, 3'd1, 16'h1111, 8'h02);
        add(0, 0, 3'b000, 3'b000, 0, 3'd1, 16'h1111, 8'h00);

        @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            rst = vecs[i].rst; stall = vecs[i].stall; req = vecs[i].req;
            req_sel = vecs[i].sel; req_data = vecs[i].data;
            @(negedge clk);
            chk($sformatf("gnt[%0d]", i),        64'(gnt),        64'(vecs[i].e_gnt));
            chk($sformatf("rf_wr_en[%0d]", i),   64'(rf_wr_en),   64'(vecs[i].e_en));
            chk($sformatf("rf_wr_sel[%0d]", i),  64'(rf_wr_sel),  64'(vecs[i].e_sel));
            chk($sformatf("rf_wr_data[%0d]", i), 64'(rf_wr_data), 64'(vecs[i].e_data));
            chk($sformatf("busy_mask[%0d]", i),  64'(busy_mask),  64'(vecs[i].e_busy));
        end

        // Lone LBI requester streams new writes (R0 first); it must win every cycle.
        for (int k = 0; k < 4; k++) begin
            logic [2:0]  s;
            logic [15:0] d;
            @(posedge clk);
            #1;
            s = 3'(k);
            d = 16'hC000 + 16'(k);
            rst = 1'b0; stall = 1'b0; req = 3'b100;
            req_sel = {s, 6'd0}; req_data = {d, 32'd0};
            @(negedge clk);
            chk($sformatf("lbi_stream_gnt[%0d]", k), 64'(gnt), 64'(3'b100));
            if (k > 0) begin
                chk($sformatf("lbi_stream_en[%0d]", k),   64'(rf_wr_en),   64'(1'b1));
                chk($sformatf("lbi_stream_data[%0d]", k), 64'(rf_wr_data), 64'(16'hC000 + 16'(k - 1)));
                chk($sformatf("lbi_stream_busy[%0d]", k), 64'(busy_mask),  64'(8'h01 << (k - 1)));
            end
        end
        @(posedge clk);
        #1;
        req = 3'b000;
        @(negedge clk);
        chk("lbi_stream_last_data", 64'(rf_wr_data), 64'(16'hC003));
        chk("lbi_stream_last_busy", 64'(busy_mask),  64'(8'h08));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("idle_en", 64'(rf_wr_en), 64'(1'b0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_rf_write_arbiter
`default_nettype wire
